// File: rtl/axis_arb_pkg.sv
// rtl/axis_arb_pkg.sv - shared types and round-robin helper for axis_packet_arbiter
//
// Contents:
//   arbState_t - arbiter state (IDLE, LOCKED)
//   TID_WIDTH  - width of the source index carried on m_axis_tid / grant_idx
//   MAX_SRC    - largest supported number of slave ports
//   rrPick_t   - result of a round-robin search (found flag + index)
//   rrNext     - first eligible source after lastGrant, wrapping at numSrc
package axis_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arbState_t;

    localparam int TID_WIDTH = 3;
    localparam int MAX_SRC   = 8;

    typedef struct packed {
        logic                 found;
        logic [TID_WIDTH-1:0] idx;
    } rrPick_t;

    // Walks the candidates from farthest to nearest so the nearest eligible
    // source after lastGrant is the one left in pick.
    function automatic rrPick_t rrNext(
        input logic [MAX_SRC-1:0]   eligible,
        input logic [TID_WIDTH-1:0] lastGrant,
        input int                   numSrc
    );
        rrPick_t pick;
        int      cand;
        pick = '0;
        for (int k = MAX_SRC; k >= 1; k--) begin
            if (k <= numSrc) begin
                cand = int'(lastGrant) + k;
                if (cand >= numSrc) begin
                    cand = cand - numSrc;
                end
                if (eligible[3'(cand)]) begin
                    pick.found = 1'b1;
                    pick.idx   = TID_WIDTH'(cand);
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// rtl/axis_reg_slice.sv - one-entry registered pipeline stage for a stream payload
//
// Ports:
//   ACLK, ARESETN         clock, asynchronous active-low reset
//   sTvalid/sTready/sTdata  upstream handshake and payload
//   mTvalid/mTready/mTdata  registered downstream handshake and payload
module axis_reg_slice #(
    parameter int WIDTH = 8
) (
    input  logic             ACLK,
    input  logic             ARESETN,
    input  logic             sTvalid,
    output logic             sTready,
    input  logic [WIDTH-1:0] sTdata,
    output logic             mTvalid,
    input  logic             mTready,
    output logic [WIDTH-1:0] mTdata
);

    // Accept whenever the register is empty or is being drained this cycle.
    assign sTready = !mTvalid || mTready;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            mTvalid <= 1'b0;
            mTdata  <= '0;
        end else if (sTvalid && sTready) begin
            mTvalid <= 1'b1;
            mTdata  <= sTdata;
        end else if (mTready) begin
            mTvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/axis_packet_arbiter.sv
// rtl/axis_packet_arbiter.sv - packet-atomic round-robin AXI4-Stream arbiter
//
// Ports:
//   ACLK, ARESETN              clock, asynchronous active-low reset
//   src_enable                 per-source arbitration enable mask
//   s_axis_*                   NUM_SRC flattened slave streams, source i at slice i
//   m_axis_*                   registered merged master stream, m_axis_tid = source
//   busy                       high while a packet grant is held
//   grant_idx                  current or most recent granted source
module axis_packet_arbiter
    import axis_arb_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 8
) (
    input  logic                             ACLK,
    input  logic                             ARESETN,
    input  logic [NUM_SRC-1:0]               src_enable,
    input  logic [NUM_SRC-1:0]               s_axis_tvalid,
    output logic [NUM_SRC-1:0]               s_axis_tready,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [NUM_SRC*DATA_WIDTH/8-1:0]  s_axis_tstrb,
    input  logic [NUM_SRC*DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [NUM_SRC*USER_WIDTH-1:0]    s_axis_tuser,
    input  logic [NUM_SRC-1:0]               s_axis_tlast,
    output logic                             m_axis_tvalid,
    input  logic                             m_axis_tready,
    output logic [DATA_WIDTH-1:0]            m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]          m_axis_tstrb,
    output logic [DATA_WIDTH/8-1:0]          m_axis_tkeep,
    output logic [USER_WIDTH-1:0]            m_axis_tuser,
    output logic                             m_axis_tlast,
    output logic [TID_WIDTH-1:0]             m_axis_tid,
    output logic                             busy,
    output logic [TID_WIDTH-1:0]             grant_idx
);

    localparam int KEEP_WIDTH    = DATA_WIDTH / 8;
    localparam int PAYLOAD_WIDTH = TID_WIDTH + 1 + USER_WIDTH + 2 * KEEP_WIDTH + DATA_WIDTH;

    arbState_t                state, stateNext;
    logic [TID_WIDTH-1:0]     grantIdx, lastGrant;
    logic [MAX_SRC-1:0]       eligible;
    rrPick_t                  pick;
    logic                     doGrant, accept, sliceReady;
    logic                     selValid, selLast;
    logic [DATA_WIDTH-1:0]    selData;
    logic [KEEP_WIDTH-1:0]    selStrb, selKeep;
    logic [USER_WIDTH-1:0]    selUser;
    logic [PAYLOAD_WIDTH-1:0] slicePayloadIn, slicePayloadOut;

    assign eligible = MAX_SRC'(s_axis_tvalid & src_enable);
    assign pick     = rrNext(eligible, lastGrant, NUM_SRC);

    // Only the granted source is ever selected, so other payloads never reach the slice.
    always_comb begin : sourceMux
        selValid = 1'b0;
        selLast  = 1'b0;
        selData  = '0;
        selStrb  = '0;
        selKeep  = '0;
        selUser  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grantIdx == TID_WIDTH'(i)) begin
                selValid = s_axis_tvalid[i];
                selLast  = s_axis_tlast[i];
                selData  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                selStrb  = s_axis_tstrb[i*KEEP_WIDTH +: KEEP_WIDTH];
                selKeep  = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
                selUser  = s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
            end
        end
    end

    always_comb begin : fsmNext
        stateNext     = state;
        doGrant       = 1'b0;
        accept        = 1'b0;
        s_axis_tready = '0;
        case (state)
            IDLE: begin
                if (pick.found) begin
                    doGrant   = 1'b1;
                    stateNext = LOCKED;
                end
            end
            LOCKED: begin
                for (int i = 0; i < NUM_SRC; i++) begin
                    if (grantIdx == TID_WIDTH'(i)) begin
                        s_axis_tready[i] = sliceReady;
                    end
                end
                accept = selValid && sliceReady;
                // Grant is only released by the last beat; a stalled source holds it forever.
                if (accept && selLast) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin : fsmState
        if (!ARESETN) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin : grantRegs
        if (!ARESETN) begin
            grantIdx  <= '0;
            lastGrant <= TID_WIDTH'(NUM_SRC - 1);
        end else begin
            if (doGrant) begin
                grantIdx <= pick.idx;
            end
            if (accept && selLast) begin
                lastGrant <= grantIdx;
            end
        end
    end

    assign slicePayloadIn = {grantIdx, selLast, selUser, selKeep, selStrb, selData};

    axis_reg_slice #(
        .WIDTH(PAYLOAD_WIDTH)
    ) outSlice (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .sTvalid (accept),
        .sTready (sliceReady),
        .sTdata  (slicePayloadIn),
        .mTvalid (m_axis_tvalid),
        .mTready (m_axis_tready),
        .mTdata  (slicePayloadOut)
    );

    assign {m_axis_tid, m_axis_tlast, m_axis_tuser, m_axis_tkeep, m_axis_tstrb, m_axis_tdata} = slicePayloadOut;

    assign busy      = (state == LOCKED);
    assign grant_idx = grantIdx;

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// tb/tb_axis_packet_arbiter.sv - self-checking bench for axis_packet_arbiter
module tb_axis_packet_arbiter;

    localparam int NS = 4;
    localparam int DW = 32;
    localparam int UW = 8;
    localparam int KW = DW / 8;

    typedef struct packed {
        logic [2:0]    tid;
        logic          last;
        logic [UW-1:0] user;
        logic [KW-1:0] keep;
        logic [KW-1:0] strb;
        logic [DW-1:0] data;
    } beat_t;

    logic             tb_ACLK = 1'b0;
    logic             ARESETN;
    logic [NS-1:0]    src_enable;
    logic [NS-1:0]    s_axis_tvalid;
    logic [NS-1:0]    s_axis_tready;
    logic [NS*DW-1:0] s_axis_tdata;
    logic [NS*KW-1:0] s_axis_tstrb;
    logic [NS*KW-1:0] s_axis_tkeep;
    logic [NS*UW-1:0] s_axis_tuser;
    logic [NS-1:0]    s_axis_tlast;
    logic             m_axis_tvalid;
    logic             m_axis_tready;
    logic [DW-1:0]    m_axis_tdata;
    logic [KW-1:0]    m_axis_tstrb;
    logic [KW-1:0]    m_axis_tkeep;
    logic [UW-1:0]    m_axis_tuser;
    logic             m_axis_tlast;
    logic [2:0]       m_axis_tid;
    logic             busy;
    logic [2:0]       grant_idx;

    always #5 tb_ACLK = ~tb_ACLK;

    axis_packet_arbiter #(
        .NUM_SRC    (NS),
        .DATA_WIDTH (DW),
        .USER_WIDTH (UW)
    ) dut (
        .ACLK          (tb_ACLK),
        .ARESETN       (ARESETN),
        .src_enable    (src_enable),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tstrb  (s_axis_tstrb),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tstrb  (m_axis_tstrb),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tid    (m_axis_tid),
        .busy          (busy),
        .grant_idx     (grant_idx)
    );

    int    cmpCnt = 0;
    int    errCnt = 0;
    beat_t srcQ[NS][$];
    beat_t mdlQ[NS][$];
    beat_t expQ[$];
    int    modelLast;
    int    gapCnt[NS];
    int    gapAtSize[NS];
    int    readyMode;
    int    patIdx;
    int    pat[4] = '{1, 0, 0, 1};
    logic  checkTiming;
    int    cyc;
    int    lastOutCyc;
    logic  lastOutWasLast;
    logic  haveOut;
    logic  prevStall;
    beat_t prevBeat;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        cmpCnt++;
        assert (obs === expv) else begin
            errCnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic beat_t outBeat();
        beat_t b;
        b.data = m_axis_tdata;
        b.strb = m_axis_tstrb;
        b.keep = m_axis_tkeep;
        b.user = m_axis_tuser;
        b.last = m_axis_tlast;
        b.tid  = m_axis_tid;
        return b;
    endfunction

    task automatic drive();
        beat_t b;
        for (int i = 0; i < NS; i++) begin
            b = '0;
            if (srcQ[i].size() > 0) b = srcQ[i][0];
            s_axis_tvalid[i]             = (srcQ[i].size() > 0) && (gapCnt[i] == 0);
            s_axis_tdata[i*DW +: DW]     = b.data;
            s_axis_tstrb[i*KW +: KW]     = b.strb;
            s_axis_tkeep[i*KW +: KW]     = b.keep;
            s_axis_tuser[i*UW +: UW]     = b.user;
            s_axis_tlast[i]              = b.last;
        end
    endtask

    task automatic addPkt(input int src, input int len, input logic [DW-1:0] base,
                          input logic [DW-1:0] stepv, input logic rnd);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.data = rnd ? DW'($urandom) : base + DW'(k) * stepv;
            b.user = UW'($urandom);
            b.keep = rnd ? KW'($urandom) : '1;
            b.strb = rnd ? KW'($urandom) : '1;
            b.last = (k == len - 1);
            b.tid  = 3'(src);
            srcQ[src].push_back(b);
            mdlQ[src].push_back(b);
        end
        drive();
    endtask

    // Reference model: whole packets in round-robin order over enabled, non-empty sources.
    task automatic buildExpected(input logic [NS-1:0] mask, input int maxPkts);
        int    n;
        bit    found;
        beat_t b;
        n = 0;
        do begin
            found = 0;
            for (int k = 1; k <= NS && !found; k++) begin
                int s;
                s = (modelLast + k) % NS;
                if (mask[s] && mdlQ[s].size() > 0) begin
                    found     = 1;
                    modelLast = s;
                    do begin
                        b = mdlQ[s].pop_front();
                        expQ.push_back(b);
                    end while (!b.last);
                    n++;
                end
            end
        end while (found && n < maxPkts);
    endtask

    task automatic step();
        logic [NS-1:0] fire;
        beat_t         e;
        @(negedge tb_ACLK);
        fire = s_axis_tvalid & s_axis_tready;
        check("one_ready", 64'($countones(s_axis_tready) <= 1), 64'(1));
        if (!busy) check("ready_idle", 64'(s_axis_tready), 64'(0));
        if (m_axis_tvalid && !m_axis_tready) check("ready_full", 64'(s_axis_tready), 64'(0));
        if (prevStall) check("stall_stable", 64'(outBeat()), 64'(prevBeat));
        prevStall = m_axis_tvalid && !m_axis_tready;
        prevBeat  = outBeat();
        if (m_axis_tvalid && m_axis_tready) begin
            if (expQ.size() == 0) begin
                check("unexpected_beat", 64'(expQ.size()), 64'(1));
            end else begin
                e = expQ.pop_front();
                check("beat", 64'(outBeat()), 64'(e));
                if (checkTiming && haveOut)
                    check("beat_spacing", 64'(cyc - lastOutCyc), lastOutWasLast ? 64'(2) : 64'(1));
                haveOut        = 1;
                lastOutCyc     = cyc;
                lastOutWasLast = e.last;
            end
        end
        @(posedge tb_ACLK);
        #1;
        cyc++;
        for (int i = 0; i < NS; i++) begin
            if (gapCnt[i] > 0) gapCnt[i]--;
            if (fire[i]) begin
                void'(srcQ[i].pop_front());
                if (srcQ[i].size() == gapAtSize[i]) begin
                    gapCnt[i]    = 5;
                    gapAtSize[i] = -1;
                end
            end
        end
        case (readyMode)
            0:       m_axis_tready = 1'b1;
            1:       begin m_axis_tready = pat[patIdx % 4] != 0; patIdx++; end
            default: m_axis_tready = ($urandom_range(0, 9) < 7);
        endcase
        drive();
    endtask

    task automatic runPhase(input int maxCyc);
        int n;
        n       = 0;
        haveOut = 0;
        while (expQ.size() > 0 && n < maxCyc) begin
            step();
            n++;
        end
        check("phase_done", 64'(expQ.size()), 64'(0));
        repeat (3) step();
    endtask

    task automatic assertReset();
        ARESETN = 1'b0;
        for (int i = 0; i < NS; i++) begin
            srcQ[i].delete();
            mdlQ[i].delete();
            gapCnt[i]    = 0;
            gapAtSize[i] = -1;
        end
        expQ.delete();
        prevStall = 0;
        drive();
    endtask

    task automatic releaseReset();
        repeat (2) @(posedge tb_ACLK);
        #1;
        ARESETN   = 1'b1;
        modelLast = NS - 1;
    endtask

    task automatic checkAllZero();
        check("rst_m_tvalid", 64'(m_axis_tvalid), 64'(0));
        check("rst_m_tlast",  64'(m_axis_tlast),  64'(0));
        check("rst_m_tdata",  64'(m_axis_tdata),  64'(0));
        check("rst_m_tstrb",  64'(m_axis_tstrb),  64'(0));
        check("rst_m_tkeep",  64'(m_axis_tkeep),  64'(0));
        check("rst_m_tuser",  64'(m_axis_tuser),  64'(0));
        check("rst_m_tid",    64'(m_axis_tid),    64'(0));
        check("rst_busy",     64'(busy),          64'(0));
        check("rst_grant",    64'(grant_idx),     64'(0));
        check("rst_s_tready", 64'(s_axis_tready), 64'(0));
    endtask

    initial begin
        int guard;
        ARESETN       = 1'b1;
        src_enable    = '1;
        m_axis_tready = 1'b1;
        readyMode     = 0;
        patIdx        = 0;
        checkTiming   = 0;
        cyc           = 0;
        haveOut       = 0;
        modelLast     = NS - 1;
        #1;
        assertReset();
        @(posedge tb_ACLK);
        #1;
        checkAllZero();
        releaseReset();

        // Single source, 4 beats, two-cycle first-beat latency.
        checkTiming = 1;
        addPkt(0, 4, 32'h01, 32'h01, 0);
        buildExpected(4'hF, 99);
        step();
        check("first_lat_1", 64'(m_axis_tvalid), 64'(0));
        step();
        check("first_lat_2", 64'(m_axis_tvalid), 64'(1));
        check("first_data",  64'(m_axis_tdata),  64'(32'h01));
        runPhase(200);

        // Fairness from reset: 0,1,2,3,0 with one bubble between packets.
        assertReset();
        releaseReset();
        addPkt(0, 2, 32'hA0, 32'h100, 0);
        addPkt(0, 2, 32'hA0, 32'h100, 0);
        for (int i = 1; i < NS; i++) addPkt(i, 2, 32'hA0 + 32'(i), 32'h100, 0);
        buildExpected(4'hF, 99);
        runPhase(300);
        checkTiming = 0;

        // Backpressure pattern 1,0,0,1 during an 8-beat packet.
        readyMode = 1;
        addPkt(2, 8, 0, 0, 1);
        buildExpected(4'hF, 99);
        runPhase(300);
        readyMode = 0;

        // Enable mask 1010: only 1 and 3 served, then the rest once re-enabled.
        src_enable = 4'b1010;
        for (int i = 0; i < NS; i++) begin
            addPkt(i, 2, 0, 0, 1);
            addPkt(i, 2, 0, 0, 1);
        end
        buildExpected(4'b1010, 99);
        runPhase(300);
        check("masked_src0_left", 64'(srcQ[0].size()), 64'(4));
        check("masked_src2_left", 64'(srcQ[2].size()), 64'(4));
        check("masked_idle",      64'(busy),           64'(0));
        src_enable = 4'b1111;
        buildExpected(4'hF, 99);
        runPhase(300);

        // Clearing src1's enable mid-packet: packet completes, then src1 skipped.
        assertReset();
        releaseReset();
        src_enable = 4'b1010;
        addPkt(1, 4, 0, 0, 1);
        addPkt(1, 4, 0, 0, 1);
        addPkt(3, 4, 0, 0, 1);
        addPkt(3, 4, 0, 0, 1);
        buildExpected(4'b1010, 1);
        guard = 0;
        while (srcQ[1].size() != 6 && guard < 50) begin step(); guard++; end
        check("clear_point_reached", 64'(srcQ[1].size()), 64'(6));
        src_enable = 4'b1000;
        buildExpected(4'b1000, 99);
        runPhase(300);
        check("src1_skipped", 64'(srcQ[1].size()), 64'(4));
        check("skip_idle",    64'(busy),           64'(0));
        src_enable = 4'b1111;
        buildExpected(4'hF, 99);
        runPhase(300);

        // src2 drops tvalid for 5 cycles mid-packet while others wait.
        assertReset();
        releaseReset();
        addPkt(2, 4, 32'h20, 32'h1, 0);
        gapAtSize[2] = 2;
        buildExpected(4'hF, 99);
        guard = 0;
        while (srcQ[2].size() != 2 && guard < 50) begin step(); guard++; end
        check("gap_point_reached", 64'(srcQ[2].size()), 64'(2));
        addPkt(0, 2, 0, 0, 1);
        addPkt(3, 2, 0, 0, 1);
        for (int k = 0; k < 5; k++) begin
            step();
            check("gap_busy",      64'(busy),                       64'(1));
            check("gap_grant",     64'(grant_idx),                  64'(2));
            check("gap_no_others", 64'(s_axis_tready & 4'b1011),    64'(0));
        end
        buildExpected(4'hF, 99);
        runPhase(300);

        // Reset at beat 3 of a packet: outputs clear at once, restart from source 0.
        addPkt(1, 4, 0, 0, 1);
        buildExpected(4'hF, 99);
        guard = 0;
        while (srcQ[1].size() != 1 && guard < 50) begin step(); guard++; end
        check("reset_point_reached", 64'(srcQ[1].size()), 64'(1));
        check("pre_reset_tvalid",    64'(m_axis_tvalid),  64'(1));
        ARESETN = 1'b0;
        #1;
        checkAllZero();
        assertReset();
        releaseReset();
        addPkt(2, 2, 0, 0, 1);
        addPkt(1, 2, 0, 0, 1);
        addPkt(0, 2, 0, 0, 1);
        buildExpected(4'hF, 99);
        step();
        step();
        check("post_reset_grant", 64'(grant_idx), 64'(0));
        check("post_reset_busy",  64'(busy),      64'(1));
        runPhase(300);

        // Randomized traffic with random backpressure.
        readyMode = 2;
        for (int r = 0; r < 8; r++) begin
            for (int s = 0; s < NS; s++) begin
                int npk;
                npk = $urandom_range(0, 2);
                for (int p = 0; p < npk; p++) addPkt(s, $urandom_range(1, 5), 0, 0, 1);
            end
            buildExpected(4'hF, 999);
            runPhase(2000);
        end

        // No eligible source: output drains and arbiter stays idle.
        readyMode = 0;
        repeat (4) step();
        check("idle_tvalid", 64'(m_axis_tvalid), 64'(0));
        check("idle_busy",   64'(busy),          64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCnt, errCnt);
        $finish;
    end

endmodule

// File: doc/axis_packet_arbiter.md
AXIS_PACKET_ARBITER -- requirements
Module: axis_packet_arbiter

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4, meaning the number of AXI4-Stream slave ports, legal range 2..8.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning the TDATA width in bits, a multiple of 8.
REQ-003 SHALL have parameter USER_WIDTH, default 8, meaning the TUSER width in bits.
REQ-004 ACLK  in  1  single clock; all logic samples on its rising edge.
REQ-005 ARESETN  in  1  reset, asynchronous assert, active-low.
REQ-006 src_enable  in  NUM_SRC  per-source arbitration enable mask.
REQ-007 s_axis_tvalid / s_axis_tready  in / out  NUM_SRC each  per-source handshake.
REQ-008 s_axis_tdata / tstrb / tkeep / tuser / tlast  in  NUM_SRC x (DATA_WIDTH, DATA_WIDTH/8, DATA_WIDTH/8, USER_WIDTH, 1)  flattened per-source payload, source i at slice i.
REQ-009 m_axis_tvalid / tready  out / in  1 each  master handshake.
REQ-010 m_axis_tdata / tstrb / tkeep / tuser / tlast  out  DATA_WIDTH, DATA_WIDTH/8, DATA_WIDTH/8, USER_WIDTH, 1  merged payload.
REQ-011 m_axis_tid  out  3  index of the source that produced the beat.
REQ-012 busy  out  1  high while a packet grant is held.
REQ-013 grant_idx  out  3  currently or last granted source index.

Function
REQ-014 The arbiter SHALL have two states: IDLE and LOCKED.
REQ-015 In IDLE, eligible sources SHALL be those with s_axis_tvalid=1 and src_enable=1.
REQ-016 In IDLE, the arbiter SHALL grant round-robin, searching from last_grant+1 modulo NUM_SRC, and SHALL register the grant and enter LOCKED on the next edge.
REQ-017 In IDLE, every s_axis_tready SHALL be 0.
REQ-018 In LOCKED, only the granted source's s_axis_tready SHALL be asserted, equal to (!m_axis_tvalid || m_axis_tready); all other trdy SHALL be 0.
REQ-019 Each accepted beat SHALL appear on the m_axis registers exactly 1 cycle later, with m_axis_tid = grant index.
REQ-020 m_axis payload SHALL stay stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-021 Back-to-back beats SHALL sustain 1 beat/cycle when m_axis_tready is held at 1.
REQ-022 The grant SHALL be packet-atomic: on acceptance of a beat with tlast=1, last_grant SHALL be set to the grant and the state SHALL return to IDLE.
REQ-023 Exactly one bubble cycle SHALL occur between packets, including when the same source is regranted.
REQ-024 If the granted source drops tvalid mid-packet, LOCKED SHALL be held indefinitely with no timeout.
REQ-025 A change in src_enable SHALL affect only the next arbitration and SHALL never break a held grant.
REQ-026 With no eligible source, the arbiter SHALL remain in IDLE, and m_axis_tvalid SHALL drop after the output register drains.
REQ-027 busy SHALL equal (state==LOCKED).
REQ-028 Payload of non-granted sources SHALL never reach the m_axis outputs.

Reset
REQ-029 While ARESETN=0, the following SHALL apply immediately (asynchronously):
- state = IDLE;
- last_grant = NUM_SRC-1, so the first grant goes to source 0;
- grant_idx = 0 and busy = 0;
- all s_axis_tready = 0;
- m_axis_tvalid = 0 and tlast = 0;
- m_axis_tdata / tstrb / tkeep / tuser / tid = 0.
REQ-030 On reset mid-packet, the partial packet SHALL be discarded with no TLAST emitted, and arbitration SHALL restart from source 0 after release.

Structure
REQ-031 Package axis_arb_pkg SHALL hold the state enum (IDLE, LOCKED), the TID width constant (3), and a function that computes the round-robin next index.
REQ-032 The output register stage SHALL be the sub-module axis_reg_slice (one-entry registered pipeline stage, parameterised by payload width).
REQ-033 The remaining logic (arbiter, mux, grant registers) SHALL be inline in axis_packet_arbiter.

Verification
REQ-034 Single source (src0 sends 4 beats 0x01..0x04 with tlast on beat 4, m_tready=1) -> output 0x01..0x04, tid=0, tlast on the 4th beat only, first output 2 cycles after s_tvalid.
REQ-035 Fairness (all 4 sources hold a 2-beat packet, payload 0xA0+i, from reset) -> output tid order 0,1,2,3,0, each packet intact, 1 bubble between packets.
REQ-036 Backpressure (m_tready toggles 1,0,0,1 during an 8-beat packet) -> no beat lost or duplicated, payload stable while stalled, s_tready of the granted source low whenever the output is full.
REQ-037 Enable mask (src_enable=4'b1010 with all sources requesting) -> only tid 1 and 3 alternate; clearing bit 1 mid-packet -> src1's packet completes, then src1 is skipped.
REQ-038 Mid-packet idle and reset:
- src2 drops tvalid for 5 cycles after beat 2 of 4 -> busy stays 1, no other source granted, packet completes;
- ARESETN asserted at beat 3 -> all outputs 0 in the same cycle, and the next packet after release is granted to source 0.
